// File: rtl/inst_fetch_if.sv
// Run-control and fetch bus between inst_fetch and its environment.
// master drives run control and decode feedback; slave is the fetch stage.
interface inst_fetch_if #(
  parameter int A_W = 10
);
  logic           Start;
  logic           Halt;
  logic           Stall;
  logic           BranchEn;
  logic [A_W-1:0] Target;
  logic [A_W-1:0] InstAddress;
  logic [A_W-1:0] PCPlus1;
  logic           InstValid;
  logic           Ack;
  logic           Wrapped;

  modport master (
    output Start, Halt, Stall, BranchEn, Target,
    input  InstAddress, PCPlus1, InstValid, Ack, Wrapped
  );

  modport slave (
    input  Start, Halt, Stall, BranchEn, Target,
    output InstAddress, PCPlus1, InstValid, Ack, Wrapped
  );
endinterface

// File: rtl/inst_fetch.sv
// PC and fetch sequencing for the 3BC core: IDLE/RUN/DONE run control.
// Build option REL_BRANCH_EN: Target is a signed PC-relative offset.
module inst_fetch #(
  parameter int A_W        = 10,
  parameter int START_ADDR = 0
) (
  input logic        Clk,
  input logic        Reset_n,
  inst_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [A_W-1:0] START_PC = A_W'(START_ADDR);

  state_e         state_q, state_d;
  logic [A_W-1:0] pc_q, pc_d;
  logic           ack_q, ack_d;
  logic           wrapped_q, wrapped_d;
  logic [A_W-1:0] pc_plus1;
  logic [A_W-1:0] branch_pc;

  assign pc_plus1 = pc_q + A_W'(1);

`ifdef REL_BRANCH_EN
  assign branch_pc = pc_q + bus.Target;
`else
  assign branch_pc = bus.Target;
`endif

  // Next-state, PC and status update; Halt > Stall > BranchEn > increment.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ack_d     = ack_q;
    wrapped_d = wrapped_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d   = RUN;
          pc_d      = START_PC;
          wrapped_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.Halt) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else if (bus.Stall) begin
          pc_d = pc_q;
        end else if (bus.BranchEn) begin
          pc_d = branch_pc;
        end else begin
          pc_d = pc_plus1;
          if (pc_q == '1) wrapped_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_d   = RUN;
          pc_d      = START_PC;
          ack_d     = 1'b0;
          wrapped_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  // Registered run state, PC and status flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ack_q     <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ack_q     <= ack_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.InstAddress = pc_q;
  assign bus.PCPlus1     = pc_plus1;
  assign bus.InstValid   = (state_q == RUN);
  assign bus.Ack         = ack_q;
  assign bus.Wrapped     = wrapped_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, sequencing, priority, wrap, restart.
// Expected values are hand-computed for both Target interpretations.
module tb_inst_fetch;

  localparam int A_W = 10;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  inst_fetch_if #(.A_W(A_W)) bus ();

  inst_fetch #(.A_W(A_W), .START_ADDR(0)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Target value that moves PC from cur to dest in either build.
  function automatic logic [A_W-1:0] tgt(input int cur, input int dest);
`ifdef REL_BRANCH_EN
    return A_W'(dest - cur);
`else
    return A_W'(dest);
`endif
  endfunction

  int exp_pc;

  initial begin
    bus.Start = 0;
    bus.Halt = 0;
    bus.Stall = 0;
    bus.BranchEn = 0;
    bus.Target = '0;

    // Reset state
    step();
    step();
    chk("rst_addr", bus.InstAddress, 0);
    chk("rst_valid", bus.InstValid, 0);
    chk("rst_ack", bus.Ack, 0);
    chk("rst_wrap", bus.Wrapped, 0);
    Reset_n = 1;
    bus.Halt = 1;
    bus.BranchEn = 1;
    bus.Target = 10'd77;
    step();
    chk("idle_addr", bus.InstAddress, 0);
    chk("idle_valid", bus.InstValid, 0);
    bus.Halt = 0;
    bus.BranchEn = 0;

    // Sequential run
    bus.Start = 1;
    step();
    bus.Start = 0;
    chk("seq0", bus.InstAddress, 0);
    chk("seq0_valid", bus.InstValid, 1);
    chk("seq0_plus1", bus.PCPlus1, 1);
    step();
    chk("seq1", bus.InstAddress, 1);
    step();
    chk("seq2", bus.InstAddress, 2);
    step();
    chk("seq3", bus.InstAddress, 3);
    bus.Halt = 1;
    step();
    bus.Halt = 0;
    chk("halt_ack", bus.Ack, 1);
    chk("halt_addr", bus.InstAddress, 3);
    chk("halt_valid", bus.InstValid, 0);
    step();
    chk("done_hold", bus.InstAddress, 3);
    chk("done_ack", bus.Ack, 1);

    // Restart from DONE, then Start in RUN is ignored
    bus.Start = 1;
    step();
    chk("rs_ack", bus.Ack, 0);
    chk("rs_addr", bus.InstAddress, 0);
    chk("rs_valid", bus.InstValid, 1);
    step();
    bus.Start = 0;
    chk("start_in_run", bus.InstAddress, 1);
    step();
    step();
    step();
    step();
    chk("pc5", bus.InstAddress, 5);

    // Priority: Stall over BranchEn, Halt over BranchEn
    bus.Stall = 1;
    bus.BranchEn = 1;
    bus.Target = 10'd20;
`ifdef REL_BRANCH_EN
    exp_pc = 25;
`else
    exp_pc = 20;
`endif
    step();
    chk("stall1", bus.InstAddress, 5);
    step();
    chk("stall2", bus.InstAddress, 5);
    bus.Stall = 0;
    step();
    chk("br_after_stall", bus.InstAddress, exp_pc);
    bus.Halt = 1;
    step();
    bus.Halt = 0;
    bus.BranchEn = 0;
    chk("halt_over_br", bus.InstAddress, exp_pc);
    chk("halt_over_br_ack", bus.Ack, 1);

    // Wrap-around
    bus.Start = 1;
    step();
    bus.Start = 0;
    chk("wr_start", bus.InstAddress, 0);
    bus.BranchEn = 1;
    bus.Target = tgt(0, 1022);
    step();
    bus.BranchEn = 0;
    chk("wr_1022", bus.InstAddress, 1022);
    chk("wr_flag0", bus.Wrapped, 0);
    step();
    chk("wr_1023", bus.InstAddress, 1023);
    chk("wr_plus1", bus.PCPlus1, 0);
    chk("wr_flag1", bus.Wrapped, 0);
    step();
    chk("wr_0", bus.InstAddress, 0);
    chk("wr_flag2", bus.Wrapped, 1);
    step();
    chk("wr_1", bus.InstAddress, 1);
    chk("wr_flag3", bus.Wrapped, 1);
    bus.Halt = 1;
    step();
    bus.Halt = 0;
    chk("wr_done_flag", bus.Wrapped, 1);
    chk("wr_done_ack", bus.Ack, 1);
    bus.Start = 1;
    step();
    bus.Start = 0;
    chk("wr_clr_flag", bus.Wrapped, 0);
    chk("wr_clr_addr", bus.InstAddress, 0);

    // Branch landing on 0 does not set Wrapped
    bus.BranchEn = 1;
    bus.Target = tgt(0, 9);
    step();
    chk("b9", bus.InstAddress, 9);
    bus.Target = tgt(9, 0);
    step();
    chk("b0", bus.InstAddress, 0);
    chk("b0_flag", bus.Wrapped, 0);

    // Relative vs absolute interpretation of Target
    bus.Target = tgt(0, 10);
    step();
    chk("b10", bus.InstAddress, 10);
    bus.Target = 10'h3FC;
`ifdef REL_BRANCH_EN
    exp_pc = 6;
`else
    exp_pc = 'h3FC;
`endif
    step();
    chk("tgt_neg4", bus.InstAddress, exp_pc);
    bus.Target = tgt(exp_pc, 1020);
    step();
    chk("b1020", bus.InstAddress, 1020);
    bus.Target = 10'd8;
`ifdef REL_BRANCH_EN
    exp_pc = 4;
`else
    exp_pc = 8;
`endif
    step();
    chk("tgt_8", bus.InstAddress, exp_pc);
    chk("tgt_8_flag", bus.Wrapped, 0);

    // Asynchronous reset mid-run at PC=37
    bus.Target = tgt(exp_pc, 37);
    step();
    bus.BranchEn = 0;
    chk("b37", bus.InstAddress, 37);
    #3;
    Reset_n = 0;
    #1;
    chk("async_addr", bus.InstAddress, 0);
    chk("async_valid", bus.InstValid, 0);
    chk("async_ack", bus.Ack, 0);
    step();
    Reset_n = 1;
    step();
    step();
    chk("post_rst_addr", bus.InstAddress, 0);
    chk("post_rst_valid", bus.InstValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
